// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state encoding and widths for the timer controller
package timer_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} timer_state_t;
    localparam int TC_W = 8;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by presc_q+1 while the timer runs
module timer_prescaler #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          run,
    input  logic [PW-1:0] presc_q,
    output logic          tick
);
    logic [PW-1:0] cnt;

    assign tick = (cnt == presc_q);

    // free-running divider, restarted from zero whenever the timer arms
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + PW'(1);
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: one-shot/periodic timer sequencing an external loadable counter (option: TIMER_CTRL_TC_COUNT_EN adds tc_cnt)
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          periodic,
    input  logic [N-1:0]  period,
    input  logic [PW-1:0] presc,
    input  logic [N-1:0]  count,
    output logic          en,
    output logic          load,
    output logic [N-1:0]  load_data,
    output logic          tc_pulse,
    output logic          busy,
`ifdef TIMER_CTRL_TC_COUNT_EN
    output logic          done,
    output logic [TC_W-1:0] tc_cnt
`else
    output logic          done
`endif
);
    timer_state_t  state, state_n;
    logic [N-1:0]  period_q;
    logic [PW-1:0] presc_q;
    logic          mode_q;
    logic          tick, hit, go;

    assign go        = start & ~stop;
    assign load_data = '0;

    timer_prescaler #(.PW(PW)) u_presc (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ARM),
        .run     (state == RUN),
        .presc_q (presc_q),
        .tick    (tick)
    );

    // state register plus command-time latches and the delayed terminal-count pulse
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            period_q <= '0;
            presc_q  <= '0;
            mode_q   <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            state    <= state_n;
            tc_pulse <= hit;
            if (go) begin
                period_q <= period;
                presc_q  <= presc;
                mode_q   <= periodic;
            end
        end

    // next state and counter controls; a one-shot hit withholds en so count parks at period_q
    always_comb begin
        hit     = (state == RUN) && tick && (count == period_q);
        en      = (state == ARM) || ((state == RUN) && tick && !(hit && !mode_q));
        load    = (state == ARM) || (hit && mode_q);
        busy    = (state == ARM) || (state == RUN);
        done    = (state == DONE);
        state_n = stop ? IDLE :
                  go ? ARM :
                  (state == ARM) ? RUN :
                  (hit && !mode_q) ? DONE : state;
    end

`ifdef TIMER_CTRL_TC_COUNT_EN
    // saturating hit counter, restarted on every arm
    always_ff @(posedge clk or posedge reset)
        if (reset)
            tc_cnt <= '0;
        else if (state_n == ARM)
            tc_cnt <= '0;
        else if (hit && tc_cnt != '1)
            tc_cnt <= tc_cnt + TC_W'(1);
`endif
endmodule
